// File: rtl/clk_duty_monitor.sv
// Measures high/low/period of a divided clock in clk cycles and flags
// duty-cycle error, phase-counter saturation and a stuck input.
module clk_duty_monitor #(
  parameter int CW      = 8,
  parameter int TOL     = 0,
  parameter int TIMEOUT = 1000
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          sig_in,
  output logic [CW-1:0] high_time,
  output logic [CW-1:0] low_time,
  output logic [CW:0]   period,
  output logic          meas_valid,
  output logic          duty_err,
  output logic          ovf,
  output logic          stuck,
  output logic [15:0]   meas_count
);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [15:0]   TO_LIM  = 16'(TIMEOUT);

  state_t        state, state_nxt;
  logic          sig_d;
  logic [CW-1:0] hi_cnt, lo_cnt, hi_nxt, lo_nxt;
  logic [15:0]   to_cnt;
  logic          rise, fall, any_edge, tmo, publish;
  logic [CW-1:0] diff;

  assign rise     = sig_in & ~sig_d;
  assign fall     = ~sig_in & sig_d;
  assign any_edge = rise | fall;
  // An edge in the same cycle as the limit always wins over the timeout.
  assign tmo      = ~any_edge && (to_cnt >= TO_LIM);
  assign diff     = (hi_cnt >= lo_cnt) ? (hi_cnt - lo_cnt) : (lo_cnt - hi_cnt);

  always_comb begin
    state_nxt = state;
    hi_nxt    = hi_cnt;
    lo_nxt    = lo_cnt;
    publish   = 1'b0;
    case (state)
      SYNC: state_nxt = IDLE;
      IDLE: if (rise) begin
        hi_nxt    = CW'(1);
        state_nxt = HIGH;
      end
      HIGH: if (fall) begin
        lo_nxt    = CW'(1);
        state_nxt = LOW;
      end else if (hi_cnt != CNT_MAX) begin
        hi_nxt = hi_cnt + CW'(1);
      end
      LOW: if (rise) begin
        publish   = 1'b1;
        hi_nxt    = CW'(1);
        state_nxt = HIGH;
      end else if (lo_cnt != CNT_MAX) begin
        lo_nxt = lo_cnt + CW'(1);
      end
      default: state_nxt = SYNC;
    endcase
    if (tmo) begin
      hi_nxt    = '0;
      lo_nxt    = '0;
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state  <= SYNC;
      sig_d  <= 1'b0;
      hi_cnt <= '0;
      lo_cnt <= '0;
      to_cnt <= '0;
    end else begin
      state  <= state_nxt;
      sig_d  <= sig_in;
      hi_cnt <= hi_nxt;
      lo_cnt <= lo_nxt;
      if (any_edge)           to_cnt <= '0;
      else if (to_cnt != '1)  to_cnt <= to_cnt + 16'd1;
    end
  end

  // Published results hold across timeouts; only a new measurement moves them.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      high_time  <= '0;
      low_time   <= '0;
      period     <= '0;
      meas_valid <= 1'b0;
      duty_err   <= 1'b0;
      ovf        <= 1'b0;
      stuck      <= 1'b0;
      meas_count <= '0;
    end else begin
      meas_valid <= publish;
      if (publish) begin
        high_time  <= hi_cnt;
        low_time   <= lo_cnt;
        period     <= {1'b0, hi_cnt} + {1'b0, lo_cnt};
        duty_err   <= (32'(diff) > 32'(TOL));
        ovf        <= (hi_cnt == CNT_MAX) || (lo_cnt == CNT_MAX);
        meas_count <= meas_count + 16'd1;
      end
      if (rise)     stuck <= 1'b0;
      else if (tmo) stuck <= 1'b1;
    end
  end

endmodule

// File: doc/clk_duty_monitor.md
# clk_duty_monitor

Measures the high time, low time and period (in `clk` cycles) of a divided-clock signal produced by the MOD-N divider stages, and flags duty-cycle error, counter saturation and stuck input. It sits directly downstream of a divider, consumes its `clk_out`, and runs in the same `clk` domain, so no synchronizer is used. It is the checking stage for divider outputs in integration and bring-up.

## Interface
- `CW`, 8: width of the high/low time counters and outputs.
- `TOL`, 0: maximum allowed |high − low| in cycles before `duty_err` is set.
- `TIMEOUT`, 1000: cycles without an edge before `stuck` is set. Valid range is 1..65535.

- `clk`  in  1  system clock; all logic on rising edge.
- `reset_L`  in  1  asynchronous reset, active-low.
- `sig_in`  in  1  divided clock under test, synchronous to `clk`.
- `high_time`  out  CW  last complete high phase, in cycles.
- `low_time`  out  CW  last complete low phase, in cycles.
- `period`  out  CW+1  `high_time + low_time`.
- `meas_valid`  out  1  one-cycle pulse when the outputs update.
- `duty_err`  out  1  |high−low| > TOL for the last measurement.
- `ovf`  out  1  either phase saturated in the last measurement.
- `stuck`  out  1  no edge for TIMEOUT cycles; level signal.
- `meas_count`  out  16  number of completed measurements; wraps at 65535→0.

## Operation
- Clock and reset are fixed: one clock; reset is asynchronous and active-low.
- `sig_d` registers `sig_in`.
  - rise = `sig_in & ~sig_d`
  - fall = `~sig_in & sig_d`
- States:
  - SYNC: reset state. Lasts one cycle, which loads `sig_d`. Edges are ignored. Always goes to IDLE.
  - IDLE: wait for a rise. On a rise: `hi_cnt`=1 → HIGH. Any partial phase seen before this rise is discarded.
  - HIGH: `hi_cnt` increments each cycle while `sig_in`=1, saturating at 2^CW−1. On a fall: `lo_cnt`=1 → LOW.
  - LOW: `lo_cnt` increments similarly, also saturating. On a rise:
    - publish `high_time`=`hi_cnt`, `low_time`=`lo_cnt`, `period`=sum (full CW+1 bits, no truncation);
    - `duty_err`=(|hi−lo|>TOL);
    - `ovf`=either count at max;
    - `meas_count`+=1, `meas_valid`=1;
    - then `hi_cnt`=1, stay measuring → HIGH.
- Timeout counter (16 bit):
  - Cleared on any rise or fall.
  - Otherwise increments, saturating.
  - When it reaches TIMEOUT: `stuck`=1, state → IDLE, and counts are discarded.
  - `stuck` clears on the next rise, which restarts measurement from IDLE. The first `meas_valid` comes only after a full period.
- A rise and a timeout in the same cycle: the edge wins. Timeout is cleared and `stuck` is not set.
- Published outputs hold until the next measurement. Timeout does not clear them.

## Timing
- Reset values: all outputs 0, `sig_d`=0, state SYNC.
- All outputs are registered.
- `meas_valid` is high for exactly the one cycle after the cycle in which the closing rise is sampled. The other outputs change in that same cycle.
- Measurement latency: 1 cycle after the closing rise.
- Minimum phase is 1 cycle. `sig_in` toggling every cycle gives a `meas_valid` every 2 cycles.
- Reset asserted mid-operation: immediate return to reset values. Partial counts are lost. After release: SYNC (1 cycle), then the first rise, then a full period before the first `meas_valid`.
- `stuck` asserts in the cycle after the timeout counter reaches TIMEOUT. It deasserts in the cycle after the clearing rise.

## Test plan
- `sig_in` from a MOD2 divider (toggles every `clk`), defaults → `high_time`=1, `low_time`=1, `period`=2, `duty_err`=0, `meas_valid` every 2nd cycle, `meas_count` increments by 1 per pulse.
- Repeating pattern 3 high / 5 low, TOL=0 → 3, 5, `period`=8, `duty_err`=1. Rerun with TOL=2 → `duty_err`=0.
- CW=8, high for 300 cycles then low for 4, TIMEOUT=1000 → `high_time`=255, `low_time`=4, `period`=259, `ovf`=1.
- TIMEOUT=20, hold `sig_in`=1 for 25 cycles → `stuck`=1 from cycle 21 after the last edge, outputs held. Resume toggling 1/1 → `stuck`=0 after the first rise, first `meas_valid` 3 cycles after that rise.
- Assert `reset_L` while in HIGH with `hi_cnt`=4 → all outputs 0 immediately. With `sig_in` high at release → no measurement until a fall then a full rise-to-rise period.
- Let `meas_count` reach 65535, then complete one more period → `meas_count`=0 with `meas_valid`=1.
